// File: rtl/frame_serializer.sv
// frame_serializer: captures a 128-bit frame from the transmit buffer when
// it reports full and sends it as NBYTES async characters (start, 8 data
// bits LSB first, stop), each bit BIT_TICKS clocks long.
// Ports:
//   i_clk      system clock, all logic on posedge
//   i_reset    synchronous active-high reset
//   i_frame    buffer contents, top byte is the oldest and is sent first
//   i_tbnfin   buffer-not-full, 0 = frame ready to send
//   o_sout     serial line, idles high
//   o_busy     high from frame capture until the end of the DONE cycle
//   o_tfin     one-cycle pulse when the frame is fully transmitted
//   o_byteidx  index of the byte currently on the line, 0 when idle
module frame_serializer #(
    parameter int BIT_TICKS = 4,
    parameter int NBYTES    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [8*NBYTES-1:0]     i_frame,
    input  logic                    i_tbnfin,
    output logic                    o_sout,
    output logic                    o_busy,
    output logic                    o_tfin,
    output logic [((NBYTES > 1) ? $clog2(NBYTES) : 1)-1:0] o_byteidx
);

    localparam int FW = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [7:0]    TICK_MAX = 8'(BIT_TICKS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [7:0]      r_tick;
    logic [2:0]      r_bitcnt;
    logic [IW-1:0]   r_byteidx;
    logic [FW-1:0]   r_shreg;
    logic            r_sout;
    logic            r_busy;
    logic            r_tfin;

    state_t          w_state_nxt;
    logic [7:0]      w_tick_nxt;
    logic [2:0]      w_bit_nxt;
    logic [IW-1:0]   w_idx_nxt;
    logic [FW-1:0]   w_shreg_nxt;
    logic            w_sout_nxt;
    logic            w_busy_nxt;
    logic            w_tfin_nxt;

    logic            w_tick_end;
    logic [7:0]      w_top;
    logic [2:0]      w_bit_inc;

    assign w_tick_end = (r_tick == TICK_MAX);
    assign w_top      = r_shreg[FW-1 -: 8];
    assign w_bit_inc  = r_bitcnt + 3'd1;

    // Every output is computed one cycle ahead so the line and status
    // flags all come straight from flops.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bitcnt;
        w_idx_nxt   = r_byteidx;
        w_shreg_nxt = r_shreg;
        w_sout_nxt  = r_sout;
        w_busy_nxt  = r_busy;
        w_tfin_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_sout_nxt = 1'b1;
                w_busy_nxt = 1'b0;
                w_idx_nxt  = '0;
                if (!i_tbnfin) begin
                    w_shreg_nxt = i_frame;
                    w_state_nxt = S_START;
                    w_sout_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_tick_nxt  = 8'd0;
                end
            end
            S_START: begin
                if (w_tick_end) begin
                    w_tick_nxt  = 8'd0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                    w_sout_nxt  = w_top[0];
                end else begin
                    w_tick_nxt = r_tick + 8'd1;
                end
            end
            S_DATA: begin
                if (w_tick_end) begin
                    w_tick_nxt = 8'd0;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_sout_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt  = w_bit_inc;
                        w_sout_nxt = w_top[w_bit_inc];
                    end
                end else begin
                    w_tick_nxt = r_tick + 8'd1;
                end
            end
            S_STOP: begin
                if (w_tick_end) begin
                    w_tick_nxt = 8'd0;
                    if (r_byteidx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                        w_tfin_nxt  = 1'b1;
                        w_sout_nxt  = 1'b1;
                    end else begin
                        // Next character follows its stop bit directly.
                        w_shreg_nxt = {r_shreg[FW-9:0], 8'h00};
                        w_idx_nxt   = r_byteidx + 1'b1;
                        w_state_nxt = S_START;
                        w_sout_nxt  = 1'b0;
                    end
                end else begin
                    w_tick_nxt = r_tick + 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_idx_nxt   = '0;
                w_sout_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sout_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_tick    <= 8'd0;
            r_bitcnt  <= 3'd0;
            r_byteidx <= '0;
            r_shreg   <= '0;
            r_sout    <= 1'b1;
            r_busy    <= 1'b0;
            r_tfin    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bitcnt  <= w_bit_nxt;
            r_byteidx <= w_idx_nxt;
            r_shreg   <= w_shreg_nxt;
            r_sout    <= w_sout_nxt;
            r_busy    <= w_busy_nxt;
            r_tfin    <= w_tfin_nxt;
        end
    end

    assign o_sout    = r_sout;
    assign o_busy    = r_busy;
    assign o_tfin    = r_tfin;
    assign o_byteidx = r_byteidx;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: two instances (BIT_TICKS=4 and 1) checked
// cycle by cycle against a queue of expected line/status values.
module tb_frame_serializer;

    typedef struct packed {
        logic       sout;
        logic       busy;
        logic       tfin;
        logic       chk_idx;
        logic [3:0] idx;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] frame0, frame1;
    logic         tbnfin0, tbnfin1;
    logic         sout0, busy0, tfin0;
    logic         sout1, busy1, tfin1;
    logic [3:0]   idx0, idx1;

    int checks   = 0;
    int failures = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    frame_serializer #(.BIT_TICKS(4), .NBYTES(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_frame(frame0), .i_tbnfin(tbnfin0),
        .o_sout(sout0), .o_busy(busy0), .o_tfin(tfin0), .o_byteidx(idx0)
    );

    frame_serializer #(.BIT_TICKS(1), .NBYTES(16)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_frame(frame1), .i_tbnfin(tbnfin1),
        .o_sout(sout1), .o_busy(busy1), .o_tfin(tfin1), .o_byteidx(idx1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t obs(input int w);
        exp_t g;
        if (w == 0) g = '{sout0, busy0, tfin0, 1'b1, idx0};
        else        g = '{sout1, busy1, tfin1, 1'b1, idx1};
        return g;
    endfunction

    function automatic exp_t mk(input logic s, input logic b, input logic t,
                                input logic c, input logic [3:0] i);
        exp_t e;
        e = '{s, b, t, c, i};
        return e;
    endfunction

    // Reference model: expected per-cycle values for one whole frame.
    task automatic push_frame(input logic [127:0] f, input int bt);
        logic [7:0] by;
        for (int b = 0; b < 16; b++) begin
            by = f[127-8*b -: 8];
            for (int t = 0; t < bt; t++) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'(b)));
            for (int k = 0; k < 8; k++)
                for (int t = 0; t < bt; t++) q.push_back(mk(by[k], 1'b1, 1'b0, 1'b1, 4'(b)));
            for (int t = 0; t < bt; t++) q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'(b)));
        end
        q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd0));
    endtask

    task automatic push_idle();
        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd0));
    endtask

    task automatic test_reset();
        exp_t g;
        reset = 1'b1;
        tbnfin0 = 1'b1;
        tbnfin1 = 1'b1;
        frame0 = '0;
        frame1 = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int w = 0; w < 2; w++) begin
                g = obs(w);
                checks++;
                if (g.sout !== 1'b1 || g.busy !== 1'b0 || g.tfin !== 1'b0 || g.idx !== 4'd0) begin
                    failures++;
                    $display("FAIL reset inst%0d cyc%0d: got s=%b b=%b t=%b i=%0d want s=1 b=0 t=0 i=0",
                             w, c, g.sout, g.busy, g.tfin, g.idx);
                end
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_char();
        exp_t e, g;
        int n;
        frame0 = '0;
        frame0[127:120] = 8'hA5;
        push_frame(frame0, 4);
        push_idle();
        tbnfin0 = 1'b0;
        tick();
        tbnfin0 = 1'b1;
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            g = obs(0);
            checks++;
            if (g.sout !== e.sout || g.busy !== e.busy || g.tfin !== e.tfin ||
                (e.chk_idx && g.idx !== e.idx)) begin
                failures++;
                $display("FAIL single_char cyc%0d: got s=%b b=%b t=%b i=%0d want s=%b b=%b t=%b i=%0d",
                         n, g.sout, g.busy, g.tfin, g.idx, e.sout, e.busy, e.tfin, e.idx);
            end
            n++;
            tick();
        end
    endtask

    task automatic test_full_frame();
        exp_t e, g;
        int n;
        int tfin_cnt;
        for (int b = 0; b < 16; b++) frame0[127-8*b -: 8] = 8'(b);
        push_frame(frame0, 4);
        push_idle();
        tbnfin0 = 1'b0;
        tick();
        tbnfin0 = 1'b1;
        n = 0;
        tfin_cnt = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            g = obs(0);
            if (g.tfin === 1'b1) tfin_cnt++;
            checks++;
            if (g.sout !== e.sout || g.busy !== e.busy || g.tfin !== e.tfin ||
                (e.chk_idx && g.idx !== e.idx)) begin
                failures++;
                $display("FAIL full_frame cyc%0d: got s=%b b=%b t=%b i=%0d want s=%b b=%b t=%b i=%0d",
                         n, g.sout, g.busy, g.tfin, g.idx, e.sout, e.busy, e.tfin, e.idx);
            end
            n++;
            tick();
        end
        checks++;
        if (tfin_cnt !== 1) begin
            failures++;
            $display("FAIL full_frame_tfin_count: got %0d want 1", tfin_cnt);
        end
    endtask

    task automatic test_latch();
        exp_t e, g;
        int n;
        for (int b = 0; b < 16; b++) frame0[127-8*b -: 8] = 8'(8'h30 + 8'(b));
        push_frame(frame0, 4);
        push_idle();
        tbnfin0 = 1'b0;
        tick();
        tbnfin0 = 1'b1;
        n = 0;
        while (q.size() > 0) begin
            if (n == 100) frame0 = '1;
            e = q.pop_front();
            g = obs(0);
            checks++;
            if (g.sout !== e.sout || g.busy !== e.busy || g.tfin !== e.tfin ||
                (e.chk_idx && g.idx !== e.idx)) begin
                failures++;
                $display("FAIL latch cyc%0d: got s=%b b=%b t=%b i=%0d want s=%b b=%b t=%b i=%0d",
                         n, g.sout, g.busy, g.tfin, g.idx, e.sout, e.busy, e.tfin, e.idx);
            end
            n++;
            tick();
        end
        frame0 = '0;
    endtask

    task automatic test_abort();
        int tf;
        frame0 = {16{8'h5A}};
        tbnfin0 = 1'b0;
        tick();
        tbnfin0 = 1'b1;
        repeat (290) tick();
        checks++;
        if (busy0 !== 1'b1 || idx0 !== 4'd7) begin
            failures++;
            $display("FAIL abort_pre: got b=%b i=%0d want b=1 i=7", busy0, idx0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (sout0 !== 1'b1 || busy0 !== 1'b0 || idx0 !== 4'd0 || tfin0 !== 1'b0) begin
            failures++;
            $display("FAIL abort_post: got s=%b b=%b t=%b i=%0d want s=1 b=0 t=0 i=0",
                     sout0, busy0, tfin0, idx0);
        end
        tf = 0;
        for (int c = 0; c < 700; c++) begin
            tick();
            if (tfin0 !== 1'b0 || busy0 !== 1'b0 || sout0 !== 1'b1) tf++;
        end
        checks++;
        if (tf != 0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", tf);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, g;
        int n;
        for (int b = 0; b < 16; b++) frame1[127-8*b -: 8] = 8'(8'hC0 ^ 8'(b * 7));
        push_frame(frame1, 1);
        push_idle();
        push_frame(frame1, 1);
        push_idle();
        tbnfin1 = 1'b0;
        tick();
        n = 0;
        while (q.size() > 0) begin
            if (n == 170) tbnfin1 = 1'b1;
            e = q.pop_front();
            g = obs(1);
            checks++;
            if (g.sout !== e.sout || g.busy !== e.busy || g.tfin !== e.tfin ||
                (e.chk_idx && g.idx !== e.idx)) begin
                failures++;
                $display("FAIL back_to_back cyc%0d: got s=%b b=%b t=%b i=%0d want s=%b b=%b t=%b i=%0d",
                         n, g.sout, g.busy, g.tfin, g.idx, e.sout, e.busy, e.tfin, e.idx);
            end
            n++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_full_frame();
        test_latch();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
